// File: rtl/csa_accumulator_pkg.sv
// Shared types and helpers for the carry-save accumulator: FSM state,
// operand width extension and the full-adder majority function.
package csa_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, OUTPUT} state_t;

    localparam int EXT_W = 64;

    // Widen a data_w-bit operand to EXT_W bits, sign- or zero-filling the top.
    function automatic logic [EXT_W-1:0] ext(input logic [EXT_W-1:0] data,
                                             input int data_w, input bit sgn);
        logic [EXT_W-1:0] r;
        r = '0;
        for (int i = 0; i < EXT_W; i++) begin
            if (i < data_w) r[i] = data[i];
            else            r[i] = sgn & data[data_w-1];
        end
        return r;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/csa_accumulator_if.sv
// Operand stream in, resolved result out; both valid/ready.
interface csa_accumulator_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count
    );
endinterface

// File: rtl/csa_row.sv
// W-wide 3:2 compressor row: per-bit full adder, carry pre-shifted left by one
// with the MSB carry dropped. With x tied to zero it degenerates to a half-add.
module csa_row
    import csa_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] x,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i] = a[i] ^ b[i] ^ x[i];
        if (i > 0) begin : g_cy
            assign carry[i] = maj3(a[i-1], b[i-1], x[i-1]);
        end
    end
endmodule

// File: rtl/csa_accumulator.sv
// Streaming accumulator holding its total in carry-save form; the carry is
// resolved only once per set, reusing the same compressor row.
module csa_accumulator
    import csa_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 8
) (
    input logic clk,
    input logic rst_n,
    csa_accumulator_if.slave bus
);
    state_t state, state_nx;

    logic [ACC_W-1:0] s, c, x, row_x, row_sum, row_carry, sum_q, ref_sum;
    logic [CNT_W-1:0] count, count_q;
    logic             valid_q, accept;

    assign x      = ACC_W'(ext(EXT_W'(bus.in_data), DATA_W, SIGNED != 0));
    assign row_x  = (state == RESOLVE) ? '0 : x;
    assign accept = bus.in_valid & bus.in_ready;

    csa_row #(.W(ACC_W)) u_row (
        .a(s), .b(c), .x(row_x), .sum(row_sum), .carry(row_carry)
    );

    always_comb begin
        state_nx     = state;
        bus.in_ready = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                bus.in_ready = 1'b1;
                if (accept) state_nx = bus.in_last ? RESOLVE : ACCUM;
            end
            RESOLVE: if (c == '0) state_nx = OUTPUT;
            OUTPUT:  if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            s       <= '0;
            c       <= '0;
            count   <= '0;
            sum_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            ref_sum <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE, ACCUM: if (accept) begin
                    s       <= row_sum;
                    c       <= row_carry;
                    count   <= (count == '1) ? count : count + 1'b1;
                    ref_sum <= ref_sum + x;
                end
                RESOLVE: begin
                    if (c == '0) begin
                        sum_q   <= s;
                        count_q <= count;
                        valid_q <= 1'b1;
                    end else begin
                        s <= row_sum;
                        c <= row_carry;
                    end
                end
                OUTPUT: if (bus.out_ready) begin
                    s       <= '0;
                    c       <= '0;
                    count   <= '0;
                    valid_q <= 1'b0;
                    ref_sum <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_count = count_q;

    // The carry-save pair must always represent the true modular running sum.
    a_csa_invariant: assert property (@(posedge clk) disable iff (!rst_n)
        (state == ACCUM || state == RESOLVE) |-> (ACC_W'(s + c) == ref_sum));
endmodule
